// File: rtl/ctrl_pipeline_if.sv
// Control-pipeline bus: ID-stage instruction fields and redirect in,
// stall and the registered ID/EX, EX/MEM and MEM/WB control bundles out.
interface ctrl_pipeline_if #(
   parameter int REG_ADDR_W = 5
);
   logic                  id_valid;
   logic [6:0]            id_op;
   logic [REG_ADDR_W-1:0] id_rd;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  flush;
   logic                  stall;

   logic                  ex_valid;
   logic                  ex_mem_read;
   logic                  ex_mem_write;
   logic                  ex_reg_write;
   logic                  ex_jump;
   logic                  ex_branch;
   logic                  ex_illegal;
   logic [REG_ADDR_W-1:0] ex_rd;

   logic                  mem_valid;
   logic                  mem_mem_read;
   logic                  mem_mem_write;
   logic                  mem_reg_write;
   logic                  mem_jump;
   logic                  mem_branch;
   logic                  mem_illegal;
   logic [REG_ADDR_W-1:0] mem_rd;

   logic                  wb_valid;
   logic                  wb_reg_write;
   logic                  wb_illegal;
   logic [REG_ADDR_W-1:0] wb_rd;

   modport master (
      output id_valid, id_op, id_rd, id_rs1, id_rs2, flush,
      input  stall,
      input  ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_jump, ex_branch, ex_illegal, ex_rd,
      input  mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_jump, mem_branch, mem_illegal, mem_rd,
      input  wb_valid, wb_reg_write, wb_illegal, wb_rd
   );

   modport slave (
      input  id_valid, id_op, id_rd, id_rs1, id_rs2, flush,
      output stall,
      output ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_jump, ex_branch, ex_illegal, ex_rd,
      output mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_jump, mem_branch, mem_illegal, mem_rd,
      output wb_valid, wb_reg_write, wb_illegal, wb_rd
   );
endinterface

// File: rtl/ctrl_pipeline.sv
// Pipelined RV32I control: decodes the ID opcode, carries the control bundle
// through ID/EX, EX/MEM and MEM/WB, and stalls ID on load-use hazards.
module ctrl_pipeline #(
   parameter int REG_ADDR_W      = 5,
   parameter int LOAD_USE_STALLS = 1
) (
   input logic           clk,
   input logic           rst,
   ctrl_pipeline_if.slave bus
);

   if (LOAD_USE_STALLS < 1 || LOAD_USE_STALLS > 3) begin : g_bad_stalls
      $error("ctrl_pipeline: LOAD_USE_STALLS must be 1..3");
   end

   typedef enum logic [6:0] {
      OP_R     = 7'b0110011,
      OP_IMM   = 7'b0010011,
      OP_LOAD  = 7'b0000011,
      OP_STORE = 7'b0100011,
      OP_BR    = 7'b1100011,
      OP_JAL   = 7'b1101111,
      OP_JALR  = 7'b1100111,
      OP_LUI   = 7'b0110111,
      OP_AUIPC = 7'b0010111
   } opcode_e;

   typedef struct packed {
      logic                  valid;
      logic                  mem_read;
      logic                  mem_write;
      logic                  reg_write;
      logic                  jump;
      logic                  branch;
      logic                  illegal;
      logic [REG_ADDR_W-1:0] rd;
   } ctrl_t;

   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic                  illegal;
      logic [REG_ADDR_W-1:0] rd;
   } wb_ctrl_t;

   localparam logic [1:0] STALL_RELOAD = 2'(LOAD_USE_STALLS - 1);

   ctrl_t      dec;
   logic       uses_rs1;
   logic       uses_rs2;
   logic       hz;
   logic [1:0] stall_cnt;
   ctrl_t      id_ex;
   ctrl_t      ex_mem;
   wb_ctrl_t   mem_wb;

   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      dec      = '0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (bus.id_op)
         OP_R:     begin dec.reg_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OP_IMM:   begin dec.reg_write = 1'b1; uses_rs1 = 1'b1; end
         OP_LOAD:  begin dec.mem_read = 1'b1; dec.reg_write = 1'b1; uses_rs1 = 1'b1; end
         OP_STORE: begin dec.mem_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OP_BR:    begin dec.branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OP_JAL:   begin dec.reg_write = 1'b1; dec.jump = 1'b1; end
         OP_JALR:  begin dec.reg_write = 1'b1; dec.jump = 1'b1; uses_rs1 = 1'b1; end
         OP_LUI:   dec.reg_write = 1'b1;
         OP_AUIPC: dec.reg_write = 1'b1;
         default:  dec.illegal = 1'b1;
      endcase
      dec.valid = 1'b1;
      // rd is meaningless without a register write; zero it so it never matches a source.
      dec.rd    = dec.reg_write ? bus.id_rd : '0;
   end

   assign hz = bus.id_valid & id_ex.valid & id_ex.mem_read & (id_ex.rd != '0) &
               ((uses_rs1 & (bus.id_rs1 == id_ex.rd)) |
                (uses_rs2 & (bus.id_rs2 == id_ex.rd)));

   assign bus.stall = ~bus.flush & (hz | (stall_cnt != 2'd0));

   // NOTE: sequential state uses non-blocking assignments so each stage samples the previous stage's old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= 2'd0;
         id_ex     <= '0;
         ex_mem    <= '0;
         mem_wb    <= '0;
      end else begin
         if (bus.flush)
            stall_cnt <= 2'd0;
         else if (hz && stall_cnt == 2'd0)
            stall_cnt <= STALL_RELOAD;
         else if (stall_cnt != 2'd0)
            stall_cnt <= stall_cnt - 2'd1;

         if (bus.flush || bus.stall || !bus.id_valid)
            id_ex <= '0;
         else
            id_ex <= dec;

         ex_mem <= id_ex;
         mem_wb <= '{valid:     ex_mem.valid,
                     reg_write: ex_mem.reg_write,
                     illegal:   ex_mem.illegal,
                     rd:        ex_mem.rd};
      end
   end

   assign bus.ex_valid      = id_ex.valid;
   assign bus.ex_mem_read   = id_ex.mem_read;
   assign bus.ex_mem_write  = id_ex.mem_write;
   assign bus.ex_reg_write  = id_ex.reg_write;
   assign bus.ex_jump       = id_ex.jump;
   assign bus.ex_branch     = id_ex.branch;
   assign bus.ex_illegal    = id_ex.illegal;
   assign bus.ex_rd         = id_ex.rd;

   assign bus.mem_valid     = ex_mem.valid;
   assign bus.mem_mem_read  = ex_mem.mem_read;
   assign bus.mem_mem_write = ex_mem.mem_write;
   assign bus.mem_reg_write = ex_mem.reg_write;
   assign bus.mem_jump      = ex_mem.jump;
   assign bus.mem_branch    = ex_mem.branch;
   assign bus.mem_illegal   = ex_mem.illegal;
   assign bus.mem_rd        = ex_mem.rd;

   assign bus.wb_valid      = mem_wb.valid;
   assign bus.wb_reg_write  = mem_wb.reg_write;
   assign bus.wb_illegal    = mem_wb.illegal;
   assign bus.wb_rd         = mem_wb.rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: three instances (LOAD_USE_STALLS = 1, 2, 3)
// share ID fields; a per-instance select gates id_valid.
module tb_ctrl_pipeline;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_BAD   = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [6:0] id_op;
   logic [4:0] id_rd, id_rs1, id_rs2;
   logic       flush;
   logic [2:0] sel;

   logic [2:0]  st, exv, mv, wv;
   logic [11:0] exb [3];
   logic [11:0] memb [3];
   logic [7:0]  wbb [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      ctrl_pipeline_if #(.REG_ADDR_W(5)) bus ();

      assign bus.id_valid = id_valid & sel[k];
      assign bus.id_op    = id_op;
      assign bus.id_rd    = id_rd;
      assign bus.id_rs1   = id_rs1;
      assign bus.id_rs2   = id_rs2;
      assign bus.flush    = flush;

      ctrl_pipeline #(.REG_ADDR_W(5), .LOAD_USE_STALLS(k + 1)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      assign st[k]   = bus.stall;
      assign exv[k]  = bus.ex_valid;
      assign mv[k]   = bus.mem_valid;
      assign wv[k]   = bus.wb_valid;
      assign exb[k]  = {bus.ex_valid, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write,
                        bus.ex_jump, bus.ex_branch, bus.ex_illegal, bus.ex_rd};
      assign memb[k] = {bus.mem_valid, bus.mem_mem_read, bus.mem_mem_write, bus.mem_reg_write,
                        bus.mem_jump, bus.mem_branch, bus.mem_illegal, bus.mem_rd};
      assign wbb[k]  = {bus.wb_valid, bus.wb_reg_write, bus.wb_illegal, bus.wb_rd};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
      id_valid = v;
      id_op    = op;
      id_rd    = rd;
      id_rs1   = rs1;
      id_rs2   = rs2;
      #1;
   endtask

   task automatic idle(input int n);
      drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // {valid, mem_read, mem_write, reg_write, jump, branch, illegal, rd}
   function automatic logic [11:0] bundle(input logic mr, input logic mw, input logic rw,
                                          input logic j, input logic b, input logic ill,
                                          input logic [4:0] rd);
      return {1'b1, mr, mw, rw, j, b, ill, rd};
   endfunction

   function automatic logic [7:0] wb_of(input logic [11:0] e);
      return {e[11], e[8], e[5], e[4:0]};
   endfunction

   // Load rd=load_rd, then op2 with rs2=load_rd on instance k; expect exp_stalls bubbles.
   task automatic load_use(input int k, input logic [4:0] load_rd, input logic [6:0] op2,
                           input int exp_stalls, input logic [4:0] exp_rd, input string tag);
      sel = 3'(1 << k);
      drive(1'b1, OP_LOAD, load_rd, 5'd1, 5'd0);
      cycle();
      check({tag, "_load_ex"}, exb[k], bundle(1, 0, 1, 0, 0, 0, load_rd));
      drive(1'b1, op2, 5'd4, 5'd1, load_rd);
      for (int j = 0; j < exp_stalls; j++) begin
         check($sformatf("%s_stall%0d", tag, j), st[k], 1);
         cycle();
         check($sformatf("%s_bubble%0d", tag, j), exv[k], 0);
      end
      check({tag, "_nostall"}, st[k], 0);
      cycle();
      check({tag, "_issue_valid"}, exv[k], 1);
      check({tag, "_issue_rd"}, exb[k][4:0], exp_rd);
      idle(3);
   endtask

   logic [6:0]  sweep_op  [10];
   logic [11:0] sweep_exp [10];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      sweep_op  = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_BAD};
      sweep_exp = '{bundle(0, 0, 1, 0, 0, 0, 5), bundle(0, 0, 1, 0, 0, 0, 5),
                    bundle(1, 0, 1, 0, 0, 0, 5), bundle(0, 1, 0, 0, 0, 0, 0),
                    bundle(0, 0, 0, 0, 1, 0, 0), bundle(0, 0, 1, 1, 0, 0, 5),
                    bundle(0, 0, 1, 1, 0, 0, 5), bundle(0, 0, 1, 0, 0, 0, 5),
                    bundle(0, 0, 1, 0, 0, 0, 5), bundle(0, 0, 0, 0, 0, 1, 0)};

      // Reset held two cycles with a live R-type in ID.
      sel   = 3'b111;
      flush = 1'b0;
      rst   = 1'b1;
      drive(1'b1, OP_R, 5'd5, 5'd1, 5'd2);
      cycle();
      cycle();
      rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_ex%0d", k), exb[k], 0);
         check($sformatf("rst_mem%0d", k), memb[k], 0);
         check($sformatf("rst_wb%0d", k), wbb[k], 0);
         check($sformatf("rst_stall%0d", k), st[k], 0);
      end
      cycle();
      check("post_rst_ex", exb[0], bundle(0, 0, 1, 0, 0, 0, 5));

      // Decode sweep, back-to-back, rd=5, sources never alias rd.
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, sweep_op[i], 5'd5, 5'd1, 5'd1);
         check($sformatf("sweep_stall%0d", i), st[0], 0);
         cycle();
         check($sformatf("sweep_ex%0d", i), exb[0], sweep_exp[i]);
         if (i >= 1) check($sformatf("sweep_mem%0d", i - 1), memb[0], sweep_exp[i - 1]);
         if (i >= 2) check($sformatf("sweep_wb%0d", i - 2), wbb[0], wb_of(sweep_exp[i - 2]));
      end
      drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
      cycle();
      check("sweep_wb8", wbb[0], wb_of(sweep_exp[8]));
      cycle();
      check("sweep_wb9", wbb[0], wb_of(sweep_exp[9]));
      idle(2);

      // Load-use hazards.
      load_use(0, 5'd3, OP_R,     1, 5'd4, "lu1_add");
      load_use(0, 5'd0, OP_R,     0, 5'd4, "lu1_rd0");
      load_use(1, 5'd3, OP_R,     2, 5'd4, "lu2_add");
      load_use(2, 5'd3, OP_R,     3, 5'd4, "lu3_add");
      load_use(2, 5'd3, OP_STORE, 3, 5'd0, "lu3_store");
      load_use(2, 5'd3, OP_LUI,   0, 5'd4, "lu3_lui");
      load_use(2, 5'd3, OP_BAD,   0, 5'd0, "lu3_illegal");

      // Flush in the hazard cycle.
      sel = 3'b001;
      drive(1'b1, OP_LOAD, 5'd3, 5'd1, 5'd0);
      cycle();
      flush = 1'b1;
      drive(1'b1, OP_R, 5'd4, 5'd1, 5'd3);
      check("flush_hz_stall", st[0], 0);
      cycle();
      flush = 1'b0;
      check("flush_hz_bubble", exv[0], 0);
      drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
      check("flush_hz_after", st[0], 0);
      idle(3);

      // Flush in the second stall cycle ends the stall (2- and 3-cycle instances).
      for (int k = 1; k < 3; k++) begin
         sel = 3'(1 << k);
         drive(1'b1, OP_LOAD, 5'd3, 5'd1, 5'd0);
         cycle();
         drive(1'b1, OP_R, 5'd4, 5'd1, 5'd3);
         check($sformatf("flush_st%0d_c1", k), st[k], 1);
         cycle();
         check($sformatf("flush_st%0d_c2", k), st[k], 1);
         flush = 1'b1;
         #1;
         check($sformatf("flush_st%0d_kill", k), st[k], 0);
         cycle();
         flush = 1'b0;
         drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
         check($sformatf("flush_st%0d_cleared", k), st[k], 0);
         check($sformatf("flush_st%0d_bubble", k), exv[k], 0);
         idle(3);
      end

      // Reset in the middle of a 3-cycle stall.
      sel = 3'b100;
      drive(1'b1, OP_LOAD, 5'd3, 5'd1, 5'd0);
      cycle();
      drive(1'b1, OP_R, 5'd4, 5'd1, 5'd3);
      cycle();
      check("rst_mid_stall_pre", st[2], 1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
      check("rst_mid_stall", st[2], 0);
      check("rst_mid_valids", {exv[2], mv[2], wv[2]}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Pipelined successor to the combinational opcode decoder.
- Decodes the RV32I opcode in ID and carries the control bundle (mem_read, mem_write, reg_write, jump, branch, rd, valid, illegal) through ID/EX, EX/MEM and MEM/WB registers.
- Adds load-use hazard detection with a parametrised stall length, bubble insertion, flush and illegal-opcode flagging.
- Sits between the IF/ID register and the datapath stage registers.

Parameters:
- REG_ADDR_W, 5, register index width.
- LOAD_USE_STALLS, 1, bubble cycles inserted per load-use hazard. Legal range 1..3; 1 = EX forwarding present, 2 = no forwarding.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_op  in  7  opcode of ID instruction.
- id_rd  in  REG_ADDR_W  destination register.
- id_rs1  in  REG_ADDR_W  source 1.
- id_rs2  in  REG_ADDR_W  source 2.
- flush  in  1  branch/jump redirect resolved in EX; kill ID instruction.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_jump, ex_branch, ex_illegal  out  1 each  ID/EX bundle.
- ex_rd  out  REG_ADDR_W  ID/EX destination.
- mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_jump, mem_branch, mem_illegal  out  1 each  EX/MEM bundle.
- mem_rd  out  REG_ADDR_W  EX/MEM destination.
- wb_valid, wb_reg_write, wb_illegal  out  1 each  MEM/WB bundle.
- wb_rd  out  REG_ADDR_W  MEM/WB destination.

Behaviour:
- Reset: one clock, synchronous, active-high, ports clk/rst. All ex_/mem_/wb_ outputs are 0 and the stall counter is 0 while rst is sampled high. stall reads 0 in the cycle after reset.
- Decode table (opcode -> mem_read, mem_write, reg_write, jump, branch; uses rs1 / uses rs2):
  - 0110011 R: 0 0 1 0 0; rs1, rs2.
  - 0010011 I-imm: 0 0 1 0 0; rs1.
  - 0000011 load: 1 0 1 0 0; rs1.
  - 0100011 store: 0 1 0 0 0; rs1, rs2.
  - 1100011 branch: 0 0 0 0 1; rs1, rs2.
  - 1101111 JAL: 0 0 1 1 0; none.
  - 1100111 JALR: 0 0 1 1 0; rs1.
  - 0110111 LUI: 0 0 1 0 0; none.
  - 0010111 AUIPC: 0 0 1 0 0; none.
  - Any other opcode: all controls 0, illegal=1, no source use.
- Decoded rd is forced to 0 when reg_write=0.
- Hazard detection (combinational): hz = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((uses_rs1 & id_rs1 == ex_rd) | (uses_rs2 & id_rs2 == ex_rd)).
- stall = !flush & (hz | stall_cnt != 0).
- Stall counter (width 2):
  - On rst or flush: 0.
  - Else if hz & stall_cnt == 0: load LOAD_USE_STALLS-1.
  - Else if stall_cnt != 0: decrement.
- ID/EX update, one rule per cycle in priority order:
  - flush -> bubble (all 0).
  - stall -> bubble.
  - !id_valid -> bubble.
  - Else -> decoded bundle with valid=1.
- EX/MEM <= ID/EX and MEM/WB <= EX/MEM every cycle. No downstream back-pressure.
- Latency: an instruction accepted in ID at cycle t appears at ex_ at t+1, mem_ at t+2, wb_ at t+3.
- Flush and hazard in the same cycle: flush wins, stall=0, counter cleared, bubble inserted.
- Illegal instructions propagate with valid=1 and illegal=1. They never assert reg_write or mem_write and never create a hazard.
- rs or rd == 0 never causes a stall.
- Reset mid-stall: counter and all stage registers clear in the same cycle. stall=0 afterwards.

Test Plan:
- Reset: drive rst=1 for 2 cycles with id_valid=1, op=0110011 -> all ex_/mem_/wb_ outputs 0 and stall=0 on the first cycle after release. The instruction then reaches ex_ one cycle later with reg_write=1.
- Decode sweep: each of the 9 opcodes plus 1111111 back-to-back with rd=5 -> ex_ bundle matches the table; store/branch give ex_rd=0; 1111111 gives ex_illegal=1. Each bundle reaches wb_ 2 cycles after ex_.
- Load-use, LOAD_USE_STALLS=1: load rd=3, then add rs2=3 -> stall=1 for exactly 1 cycle and one bubble at ex_. The add appears at ex_ 2 cycles after the load. With rd=0 there is no stall.
- Load-use, LOAD_USE_STALLS=3: same sequence -> stall high 3 consecutive cycles, 3 bubbles, then the add issues. With a store using rs2=3, the stall still occurs; with LUI, no stall.
- Flush priority: raise flush in the cycle hz=1 -> stall=0, ex_valid=0 next cycle, counter 0. With LOAD_USE_STALLS=2, flush in the second stall cycle ends the stall immediately.
- Reset mid-stall: assert rst during a 3-cycle stall -> next cycle stall=0 and all stage valids 0.
